// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the combination-lock front end.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } db_state_t;

    localparam int COMBO_W                 = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/input_conditioner_if.sv
// Button/switch inputs and conditioned strobes/code between the board and the lock FSM.
interface input_conditioner_if;
    import lock_pkg::*;

    logic               changeKey;
    logic               enterKey;
    logic [COMBO_W-1:0] SW;
    logic               changePulse;
    logic               enterPulse;
    logic [COMBO_W-1:0] X;

    modport master (
        output changeKey, enterKey, SW,
        input  changePulse, enterPulse, X
    );

    modport slave (
        input  changeKey, enterKey, SW,
        output changePulse, enterPulse, X
    );

endinterface

// File: rtl/input_conditioner_debounce_fsm.sv
// Per-button synchronizer plus debounce FSM; strobe is combinational and is registered by the top.
module debounce_fsm
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic pressed,
    output logic strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync_p0;
    logic             r_sync_p1;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);

    // stage p0/p1: two-flop synchronizer, reset to the released level
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= pressed;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Starting in HELD means a key held through reset must be released before it can count.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= HELD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_sync_p1) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync_p1)    r_state <= IDLE;
                    else if (w_at_last) r_state <= HELD;
                    else               r_cnt   <= r_cnt + CNT_W'(1);
                end
                HELD: begin
                    if (!r_sync_p1) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync_p1)      r_state <= HELD;
                    else if (w_at_last) r_state <= IDLE;
                    else                r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= HELD;
            endcase
        end
    end

    assign strobe = (r_state == PRESS_WAIT) && r_sync_p1 && w_at_last;

endmodule

// File: rtl/input_conditioner.sv
// Lock front end: debounced single-cycle change/enter strobes and a code X captured with each strobe.
module input_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                Clock,
    input  logic                Resetn,
    input_conditioner_if.slave  bus
);

    logic [COMBO_W-1:0] r_sw_p0;
    logic [COMBO_W-1:0] r_sw_p1;
    logic               r_change_pulse;
    logic               r_enter_pulse;
    logic [COMBO_W-1:0] r_x;
    logic               w_change_lvl;
    logic               w_enter_lvl;
    logic               w_change_strobe;
    logic               w_enter_strobe;

    assign w_change_lvl = bus.changeKey ^ ACTIVE_LOW;
    assign w_enter_lvl  = bus.enterKey  ^ ACTIVE_LOW;

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_change_db (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .pressed (w_change_lvl),
        .strobe  (w_change_strobe)
    );

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_enter_db (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .pressed (w_enter_lvl),
        .strobe  (w_enter_strobe)
    );

    // stage p0/p1: switch-code synchronizer
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sw_p0 <= '0;
            r_sw_p1 <= '0;
        end else begin
            r_sw_p0 <= bus.SW;
            r_sw_p1 <= r_sw_p0;
        end
    end

    // output stage: enter wins a tie and the change press is dropped, not deferred
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_change_pulse <= 1'b0;
            r_enter_pulse  <= 1'b0;
            r_x            <= '0;
        end else begin
            r_change_pulse <= w_change_strobe && !w_enter_strobe;
            r_enter_pulse  <= w_enter_strobe;
            if (w_change_strobe || w_enter_strobe) r_x <= r_sw_p1;
        end
    end

    assign bus.changePulse = r_change_pulse;
    assign bus.enterPulse  = r_enter_pulse;
    assign bus.X           = r_x;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the combination lock: it turns the two raw pushbuttons and the 4-bit switch bank into clean single-cycle `changePulse`/`enterPulse` strobes and a stable 4-bit code `X`, and it feeds the lock FSM directly. It synchronizes every asynchronous input, debounces each button with a 4-state FSM, and guarantees one pulse per physical press. It also samples the switch code in the same cycle as the pulse, so the lock always compares a stable value.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a button level must be stable (10 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `ACTIVE_LOW`, default 1: 1 means a raw button reads 0 when pressed (board KEYs).
- `Clock` in 1: sole clock; all logic is on posedge.
- `Resetn` in 1: asynchronous, active-low reset.
- `changeKey` in 1: raw, asynchronous change button.
- `enterKey` in 1: raw, asynchronous enter button.
- `SW` in 4: raw, asynchronous switch code.
- `changePulse` out 1: registered one-cycle strobe per qualified change press.
- `enterPulse` out 1: registered one-cycle strobe per qualified enter press.
- `X` out 4: registered code, loaded from the synchronized `SW` on every pulse cycle.

## Operation
- **Synchronizers:** two-flop synchronizer on each button and on each `SW` bit. Button flops reset to the released level; `SW` flops reset to 0.
- **Normalized level:** `pressed = sync ^ ACTIVE_LOW`.
- **Debounce FSM:** one per button, with a private counter `cnt`.
  - IDLE: if pressed, go to PRESS_WAIT with `cnt = 0`.
  - PRESS_WAIT:
    - If released, go to IDLE.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, go to HELD and assert the raw strobe for one cycle.
    - Else increment `cnt`.
  - HELD: if released, go to RELEASE_WAIT with `cnt = 0`. No further strobes while in HELD, whatever the hold length.
  - RELEASE_WAIT:
    - If pressed, go back to HELD with no strobe.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, go to IDLE.
    - Else increment `cnt`.
- **Reset state is HELD.** A button held through reset never produces a pulse; it must first be released for `DEBOUNCE_CYCLES` cycles.
- **Arbitration:** if both raw strobes fire in the same cycle, `enterPulse` = 1 and `changePulse` = 0. The change press is dropped, not deferred. Its FSM still goes to HELD.
- **Code capture:** on any cycle where either output pulse is registered high, `X` loads the synchronized `SW` on that same edge. Otherwise `X` holds. `X` never changes between pulses.
- **Counter:** `CNT_W` bits, unsigned, never wraps (it is cleared on every state entry that uses it).

## Timing
- **Reset values:** `changePulse` = 0, `enterPulse` = 0, `X` = 0, both FSMs in HELD, counters 0.
- **Reset is asynchronous.** Asserting it mid-debounce abandons the press immediately, and any in-flight pulse is cleared.
- **Press latency:** the raw press is first captured at edge k. The pulse is high for exactly one cycle, from edge k+DEBOUNCE_CYCLES+2 to edge k+DEBOUNCE_CYCLES+3.
- **`X` timing:** `X` updates on the same edge the pulse rises. It reflects `SW` as captured 2 edges earlier (synchronizer delay).
- **Bounce rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles in PRESS_WAIT produces no pulse. A glitch shorter than `DEBOUNCE_CYCLES` cycles in RELEASE_WAIT produces no second pulse.
- **Minimum spacing:** two accepted presses on the same button are at least 2·`DEBOUNCE_CYCLES`+1 cycles apart.

## Structure
- **Package `lock_pkg`:**
  - 2-bit debounce state enum: IDLE=00, PRESS_WAIT=01, HELD=10, RELEASE_WAIT=11.
  - Lock combo width constant (4).
  - Default `DEBOUNCE_CYCLES`.
- **Sub-module `debounce_fsm`:**
  - Parameters: `DEBOUNCE_CYCLES`, `CNT_W`.
  - Ports: `Clock`, `Resetn`, `pressed` in, `strobe` out.
  - Contains its own synchronizer, the FSM and the counter.
  - Instantiated twice.
- **Top level:** `SW` synchronizer, arbitration logic, output pulse registers and the `X` register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `ACTIVE_LOW` = 1.
- **Reset:** `enterKey` = 0 (pressed) through reset and 20 cycles after it → no `enterPulse`; `X` = 0. Then release for ≥5 cycles and press cleanly → exactly one `enterPulse`.
- **Clean press:** `SW` = 0110, `enterKey` low for 50 cycles starting at edge k → `enterPulse` = 1 only in the cycle after edge k+6, with `X` = 0110 on that same edge.
- **Bounce:** `changeKey` toggles low for 2 cycles, high for 1, low for 3, then holds low → exactly one `changePulse`, 4 cycles after the last stable low begins being counted. A 2-cycle release glitch while held → no second pulse.
- **Simultaneous:** both keys pressed on the same edge with `SW` = 1010 → `enterPulse` = 1, `changePulse` = 0, `X` = 1010. No `changePulse` on any later cycle until `changeKey` is released and pressed again.
- **Reset mid-debounce:** `Resetn` pulsed low during PRESS_WAIT (cnt = 2) → no pulse; `X` = 0; the held button yields no pulse until it is released and pressed again.
- **Code stability:** `SW` changes from 0110 to 1111 between pulses → `X` stays 0110 until the next accepted pulse, then becomes 1111.
